// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared defaults and saturating-counter helpers for the gshare predictor
package bp_pkg;
  localparam int INDEX_BITS_DEF = 7;
  localparam int CTR_BITS_DEF   = 2;
  localparam int HIST_BITS_DEF  = 7;
  localparam int CTR_MAX_BITS   = 4;

  typedef logic [CTR_BITS_DEF-1:0] ctr_t;

  // Helpers work on the widest legal counter; callers pass their real width in bits.
  function automatic logic [CTR_MAX_BITS-1:0] ctr_next(input logic [CTR_MAX_BITS-1:0] c,
                                                       input logic taken, input int bits);
    logic [CTR_MAX_BITS-1:0] max_v;
    max_v = CTR_MAX_BITS'((32'd1 << bits) - 32'd1);
    if (taken) return (c == max_v) ? c : c + 1'b1;
    else       return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [CTR_MAX_BITS-1:0] ctr_init(input int bits);
    return CTR_MAX_BITS'((32'd1 << (bits - 1)) - 32'd1);
  endfunction
endpackage

// File: rtl/gshare_pht_if.sv
// rtl/gshare_pht_if.sv - lookup/prediction/update bundle between fetch, branch unit and PHT
interface gshare_pht_if #(
  parameter int HIST_BITS = 7
);
  // A zero-length history still needs a 1-bit carrier; the PHT ties it to zero.
  localparam int HW = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic          lookup_valid;
  logic [31:0]   lookup_pc;
  logic          pred_valid;
  logic          pred_taken;
  logic [HW-1:0] pred_hist;
  logic          update_valid;
  logic [31:0]   update_pc;
  logic [HW-1:0] update_hist;
  logic          update_taken;
  logic [HW-1:0] ghr;

  modport master (
    output lookup_valid, lookup_pc, update_valid, update_pc, update_hist, update_taken,
    input  pred_valid, pred_taken, pred_hist, ghr
  );
  modport slave (
    input  lookup_valid, lookup_pc, update_valid, update_pc, update_hist, update_taken,
    output pred_valid, pred_taken, pred_hist, ghr
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - one saturating prediction counter with async reset to weakly not-taken
module sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_BITS = CTR_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                outcome,
  output logic [CTR_BITS-1:0] value,
  output logic                predict
);
  logic [CTR_BITS-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) value_d = CTR_BITS'(ctr_next(CTR_MAX_BITS'(value_q), outcome, CTR_BITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= CTR_BITS'(ctr_init(CTR_BITS));
    else        value_q <= value_d;
  end

  assign value   = value_q;
  assign predict = value_q[CTR_BITS-1];
endmodule

// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - gshare pattern history table: PC^GHR indexed counters, registered prediction
module gshare_pht
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int CTR_BITS   = CTR_BITS_DEF,
  parameter int HIST_BITS  = HIST_BITS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  gshare_pht_if.slave  bus
);
  localparam int HW      = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [INDEX_BITS-1:0] hist_l, hist_u, lookup_idx, update_idx;
  logic [HW-1:0]         ghr_q, ghr_d, pred_hist_q, pred_hist_d;
  logic                  pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
  logic                  bypass, bypass_taken;
  logic [CTR_BITS-1:0]   ctr_val [ENTRIES];
  logic [ENTRIES-1:0]    ctr_pred, ctr_load;
  logic                  unused_bits;

  if (HIST_BITS > 0) begin : g_hist
    assign hist_l = INDEX_BITS'(ghr_q);
    assign hist_u = INDEX_BITS'(bus.update_hist);
  end else begin : g_nohist
    assign hist_l = '0;
    assign hist_u = '0;
  end

  assign lookup_idx  = bus.lookup_pc[INDEX_BITS+1:2] ^ hist_l;
  assign update_idx  = bus.update_pc[INDEX_BITS+1:2] ^ hist_u;
  assign unused_bits = ^{bus.lookup_pc[31:INDEX_BITS+2], bus.lookup_pc[1:0],
                         bus.update_pc[31:INDEX_BITS+2], bus.update_pc[1:0], bus.update_hist};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    assign ctr_load[i] = bus.update_valid && (update_idx == INDEX_BITS'(i));
    sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ctr_load[i]),
      .outcome (bus.update_taken),
      .value   (ctr_val[i]),
      .predict (ctr_pred[i])
    );
  end

  always_comb begin
    ghr_d        = ghr_q;
    pred_valid_d = bus.lookup_valid;
    pred_taken_d = pred_taken_q;
    pred_hist_d  = pred_hist_q;
    bypass       = bus.update_valid && (update_idx == lookup_idx);
    // Post-update counter is above the init value exactly when its MSB is set.
    bypass_taken = ctr_next(CTR_MAX_BITS'(ctr_val[update_idx]), bus.update_taken, CTR_BITS)
                   > ctr_init(CTR_BITS);
    if (bus.update_valid && (HIST_BITS > 0)) ghr_d = HW'({ghr_q, bus.update_taken});
    if (bus.lookup_valid) begin
      pred_taken_d = bypass ? bypass_taken : ctr_pred[lookup_idx];
      pred_hist_d  = ghr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_hist_q  <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_hist_q  <= pred_hist_d;
    end
  end

  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.pred_hist  = pred_hist_q;
  assign bus.ghr        = ghr_q;
endmodule

// File: tb/tb_gshare_pht.sv
// tb/tb_gshare_pht.sv - three PHT configurations on shared stimulus against a table model
module tb_gshare_pht;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        lv, uv, ut;
  logic [31:0] lpc, upc;
  logic [6:0]  uhist;

  always #5 clk = ~clk;

  gshare_pht_if #(.HIST_BITS(7)) if0 ();
  gshare_pht_if #(.HIST_BITS(0)) if1 ();
  gshare_pht_if #(.HIST_BITS(0)) if2 ();

  assign if0.lookup_valid = lv;  assign if1.lookup_valid = lv;  assign if2.lookup_valid = lv;
  assign if0.lookup_pc    = lpc; assign if1.lookup_pc    = lpc; assign if2.lookup_pc    = lpc;
  assign if0.update_valid = uv;  assign if1.update_valid = uv;  assign if2.update_valid = uv;
  assign if0.update_pc    = upc; assign if1.update_pc    = upc; assign if2.update_pc    = upc;
  assign if0.update_taken = ut;  assign if1.update_taken = ut;  assign if2.update_taken = ut;
  assign if0.update_hist  = uhist;
  assign if1.update_hist  = uhist[0];
  assign if2.update_hist  = uhist[0];

  gshare_pht #(.INDEX_BITS(7), .CTR_BITS(2), .HIST_BITS(7)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  gshare_pht #(.INDEX_BITS(7), .CTR_BITS(2), .HIST_BITS(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  gshare_pht #(.INDEX_BITS(7), .CTR_BITS(3), .HIST_BITS(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  localparam int CB [3] = '{2, 2, 3};
  localparam int HB [3] = '{7, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;
  int mctr [3][128];
  int mghr [3];
  int mpv  [3];
  int mpt  [3];
  int mph  [3];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 128; i++) mctr[k][i] = (1 << (CB[k] - 1)) - 1;
      mghr[k] = 0; mpv[k] = 0; mpt[k] = 0; mph[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int hm, top, old, li, ui;
      hm  = (1 << HB[k]) - 1;
      top = (1 << CB[k]) - 1;
      old = mghr[k];
      li  = int'(lpc[8:2]) ^ (old & hm);
      ui  = int'(upc[8:2]) ^ (int'(uhist) & hm);
      if (uv) begin
        if (ut) mctr[k][ui] = (mctr[k][ui] == top) ? top : mctr[k][ui] + 1;
        else    mctr[k][ui] = (mctr[k][ui] == 0) ? 0 : mctr[k][ui] - 1;
        mghr[k] = ((old << 1) | int'(ut)) & hm;
      end
      mpv[k] = int'(lv);
      if (lv) begin
        mpt[k] = (mctr[k][li] > top / 2) ? 1 : 0;
        mph[k] = old;
      end
    end
  endtask

  task automatic compare_all();
    check("pv0", int'(if0.pred_valid), mpv[0]);
    check("pt0", int'(if0.pred_taken), mpt[0]);
    check("ph0", int'(if0.pred_hist),  mph[0]);
    check("ghr0", int'(if0.ghr),       mghr[0]);
    check("pv1", int'(if1.pred_valid), mpv[1]);
    check("pt1", int'(if1.pred_taken), mpt[1]);
    check("ghr1", int'(if1.ghr),       0);
    check("pv2", int'(if2.pred_valid), mpv[2]);
    check("pt2", int'(if2.pred_taken), mpt[2]);
  endtask

  task automatic drive(input logic l_v, input logic [31:0] l_pc, input logic u_v,
                       input logic [31:0] u_pc, input logic [6:0] u_h, input logic u_t);
    lv = l_v; lpc = l_pc; uv = u_v; upc = u_pc; uhist = u_h; ut = u_t;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Called 1ns after an edge: reset lands mid-cycle and outputs must clear before the next edge.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pv0", int'(if0.pred_valid), 0);
    check("rst_pt0", int'(if0.pred_taken), 0);
    check("rst_ghr0", int'(if0.ghr), 0);
    check("rst_pt1", int'(if1.pred_taken), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  int exp_dn2 [4] = '{1, 0, 0, 0};
  int exp_dn3 [4] = '{1, 1, 1, 0};
  int exp_t3  [4] = '{1, 1, 0, 1};

  initial begin
    logic [31:0] a, b;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    compare_all();

    drive(1'b1, 32'h100, 1'b0, '0, '0, 1'b0); step();
    check("t1_pv", int'(if0.pred_valid), 1);
    check("t1_pt", int'(if0.pred_taken), 0);
    check("t1_ph", int'(if0.pred_hist), 0);
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 32'(i) << 2, 1'b0, '0, '0, 1'b0); step();
      check("t1_sweep", int'(if0.pred_taken), 0);
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0); step();
    check("t1_pv_drop", int'(if0.pred_valid), 0);

    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, 1'b1, 32'h40, '0, 1'b1); step();
      drive(1'b1, 32'h40, 1'b0, '0, '0, 1'b0); step();
      check("t2_up2", int'(if1.pred_taken), 1);
      check("t6_up3", int'(if2.pred_taken), 1);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1, 32'h40, '0, 1'b0); step();
      drive(1'b1, 32'h40, 1'b0, '0, '0, 1'b0); step();
      check("t2_dn2", int'(if1.pred_taken), exp_dn2[k]);
      check("t6_dn3", int'(if2.pred_taken), exp_dn3[k]);
    end

    apply_reset();
    repeat (2) begin drive(1'b0, '0, 1'b1, 32'h34, '0, 1'b1); step(); end
    repeat (3) begin drive(1'b0, '0, 1'b1, 32'h80, '0, 1'b0); step(); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1, 32'h80, '0, exp_t3[k] != 0); step();
    end
    check("t3_ghr", int'(if0.ghr), 'h0D);
    drive(1'b1, 32'h0, 1'b0, '0, '0, 1'b0); step();
    check("t3_ph", int'(if0.pred_hist), 'h0D);
    check("t3_pt", int'(if0.pred_taken), 1);

    apply_reset();
    drive(1'b1, 32'h40, 1'b1, 32'h40, '0, 1'b1); step();
    check("t4_same0", int'(if0.pred_taken), 1);
    check("t4_same1", int'(if1.pred_taken), 1);
    apply_reset();
    drive(1'b1, 32'h40, 1'b1, 32'h44, '0, 1'b1); step();
    check("t4_diff0", int'(if0.pred_taken), 0);

    apply_reset();
    repeat (3) begin drive(1'b0, '0, 1'b1, 32'h40, '0, 1'b1); step(); end
    drive(1'b1, 32'h40, 1'b0, '0, '0, 1'b0); step();
    check("t5_pre", int'(if1.pred_taken), 1);
    apply_reset();
    drive(1'b1, 32'h40, 1'b0, '0, '0, 1'b0); step();
    check("t5_post", int'(if1.pred_taken), 0);

    for (int n = 0; n < 3000; n++) begin
      b = ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) != 0) ? b : $urandom;
      drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0, b,
            ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 3)) : 7'($urandom),
            $urandom_range(0, 2) != 0);
      step();
      if ($urandom_range(0, 499) == 0) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
